board_render_ctrl: RTL



---
 rtl/board_render_ctrl_pkg.sv | 25 ++
 rtl/board_render_ctrl_if.sv | 29 ++
 rtl/board_scan_decode.sv | 46 ++++
 rtl/board_render_ctrl.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/board_render_ctrl_pkg.sv
// Shared constants, FSM state type and address helpers for the board render controller.
package board_render_ctrl_pkg;

  localparam int unsigned TILE_PX     = 64;
  localparam int unsigned TILE_LOG2   = 6;
  localparam int unsigned BOARD_TILES = 4;
  localparam int unsigned BOARD_PX    = TILE_PX * BOARD_TILES;
  localparam int unsigned ADDR_W      = 4;
  localparam int unsigned VAL_W       = 4;
  localparam int unsigned POS_W       = 10;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StFull
  } fsm_state_e;

  typedef logic [ADDR_W-1:0] tile_addr_t;
  typedef logic [VAL_W-1:0]  tile_val_t;

  function automatic tile_addr_t tile_addr(input logic [1:0] row, input logic [1:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/board_render_ctrl_if.sv
// Beam position, board read port and glyph renderer signals of the board render controller.
interface board_render_ctrl_if;

  logic [board_render_ctrl_pkg::POS_W-1:0] hpos;
  logic [board_render_ctrl_pkg::POS_W-1:0] vpos;
  logic                                    frame_start;
  logic                                    rd_req;
  board_render_ctrl_pkg::tile_addr_t       rd_addr;
  logic                                    rd_ack;
  board_render_ctrl_pkg::tile_val_t        rd_data;
  board_render_ctrl_pkg::tile_val_t        num_index;
  logic [board_render_ctrl_pkg::TILE_LOG2-1:0] num_x;
  logic [board_render_ctrl_pkg::TILE_LOG2-1:0] num_y;
  logic                                    in_board;
  logic                                    underrun;

  // Controller side: issues board reads and drives the glyph renderer.
  modport master (
    input  hpos, vpos, frame_start, rd_ack, rd_data,
    output rd_req, rd_addr, num_index, num_x, num_y, in_board, underrun
  );

  // Environment side: timing generator, board store and renderer.
  modport slave (
    output hpos, vpos, frame_start, rd_ack, rd_data,
    input  rd_req, rd_addr, num_index, num_x, num_y, in_board, underrun
  );

endinterface

// File: rtl/board_scan_decode.sv
// Combinational beam-position decode: board offsets, hit window and fetch/commit strobes.
module board_scan_decode
  import board_render_ctrl_pkg::*;
#(
  parameter int unsigned BOARD_X0 = 192,
  parameter int unsigned BOARD_Y0 = 112,
  parameter int unsigned LEAD     = 8
) (
  input  logic [POS_W-1:0]     hpos_i,
  input  logic [POS_W-1:0]     vpos_i,
  output logic [TILE_LOG2-1:0] bx_o,
  output logic [7:0]           by_o,
  output logic                 row_valid_o,
  output logic                 hit_o,
  output logic                 trigger_o,
  output logic                 boundary_o,
  output logic [1:0]           trig_col_o
);

  localparam logic [POS_W-1:0] X0  = POS_W'(BOARD_X0);
  localparam logic [POS_W-1:0] Y0  = POS_W'(BOARD_Y0);
  localparam logic [POS_W-1:0] LD  = POS_W'(LEAD);
  localparam logic [POS_W-1:0] BPX = POS_W'(BOARD_PX);

  logic [POS_W-1:0] bx;
  logic [POS_W-1:0] by;
  logic [POS_W-1:0] lead_off;

  assign bx = hpos_i - X0;
  assign by = vpos_i - Y0;

  // Wrapping offsets make each window a single unsigned compare.
  assign row_valid_o = (by < BPX);
  assign hit_o       = row_valid_o && (bx < BPX);

  // Position as seen LEAD pixels ahead; a tile edge there is a fetch trigger here.
  assign lead_off    = hpos_i + LD - X0;
  assign trigger_o   = row_valid_o && (lead_off < BPX) && (lead_off[TILE_LOG2-1:0] == '0);
  assign trig_col_o  = lead_off[TILE_LOG2+1:TILE_LOG2];

  assign boundary_o  = hit_o && (bx[TILE_LOG2-1:0] == '0);

  assign bx_o = bx[TILE_LOG2-1:0];
  assign by_o = by[7:0];

endmodule

// File: rtl/board_render_ctrl.sv
// Prefetches each board tile's exponent ahead of the beam and drives the glyph renderer.
module board_render_ctrl
  import board_render_ctrl_pkg::*;
#(
  parameter int unsigned BOARD_X0 = 192,
  parameter int unsigned BOARD_Y0 = 112,
  parameter int unsigned LEAD     = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  board_render_ctrl_if.master bus
);

  logic [TILE_LOG2-1:0] bx;
  logic [7:0]           by;
  logic                 row_valid;
  logic                 hit;
  logic                 trigger;
  logic                 boundary;
  logic [1:0]           trig_col;

  board_scan_decode #(
    .BOARD_X0 (BOARD_X0),
    .BOARD_Y0 (BOARD_Y0),
    .LEAD     (LEAD)
  ) u_decode (
    .hpos_i      (bus.hpos),
    .vpos_i      (bus.vpos),
    .bx_o        (bx),
    .by_o        (by),
    .row_valid_o (row_valid),
    .hit_o       (hit),
    .trigger_o   (trigger),
    .boundary_o  (boundary),
    .trig_col_o  (trig_col)
  );

  fsm_state_e           state_q;
  logic                 rd_req_q;
  tile_addr_t           rd_addr_q;
  tile_val_t            next_val_q;
  tile_val_t            cur_val_q;
  logic                 underrun_q;
  tile_val_t            num_index_q;
  logic [TILE_LOG2-1:0] num_x_q;
  logic [TILE_LOG2-1:0] num_y_q;
  logic                 in_board_q;

  tile_val_t            commit_val;
  tile_val_t            pix_val;
  logic                 miss;

  // Value that becomes current if this cycle is a tile boundary.
  always_comb begin
    commit_val = cur_val_q;
    case (state_q)
      StFull:  commit_val = next_val_q;
      StReq:   commit_val = bus.rd_ack ? bus.rd_data : '0;
      default: commit_val = cur_val_q;
    endcase
  end

  assign pix_val = boundary ? commit_val : cur_val_q;
  assign miss    = (state_q == StReq) && boundary && !bus.rd_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      rd_req_q   <= 1'b0;
      rd_addr_q  <= '0;
      next_val_q <= '0;
      cur_val_q  <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (trigger) begin
            state_q   <= StReq;
            rd_req_q  <= 1'b1;
            rd_addr_q <= tile_addr(by[7:6], trig_col);
          end
        end
        StReq: begin
          if (bus.rd_ack) begin
            rd_req_q <= 1'b0;
            // A grant landing on the boundary itself is still in time.
            if (boundary) begin
              cur_val_q <= bus.rd_data;
              state_q   <= StIdle;
            end else begin
              next_val_q <= bus.rd_data;
              state_q    <= StFull;
            end
          end else if (boundary) begin
            rd_req_q  <= 1'b0;
            cur_val_q <= '0;
            state_q   <= StIdle;
          end
        end
        StFull: begin
          if (boundary) begin
            cur_val_q <= next_val_q;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underrun_q <= 1'b0;
    end else if (miss) begin
      underrun_q <= 1'b1;
    end else if (bus.frame_start) begin
      underrun_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_board_q  <= 1'b0;
      num_x_q     <= '0;
      num_y_q     <= '0;
      num_index_q <= '0;
    end else begin
      in_board_q  <= hit;
      num_x_q     <= hit ? bx : '0;
      num_y_q     <= hit ? by[TILE_LOG2-1:0] : '0;
      num_index_q <= hit ? pix_val : '0;
    end
  end

  assign bus.rd_req    = rd_req_q;
  assign bus.rd_addr   = rd_addr_q;
  assign bus.num_index = num_index_q;
  assign bus.num_x     = num_x_q;
  assign bus.num_y     = num_y_q;
  assign bus.in_board  = in_board_q;
  assign bus.underrun  = underrun_q;

  // row_valid is folded into hit/trigger inside the decoder; kept visible for debug.
  logic row_valid_dbg;
  assign row_valid_dbg = row_valid;

endmodule
